sht40_convert: RTL

SHT40_CONVERT -- requirements
Module: sht40_convert

---
 rtl/sht40_convert.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sht40_convert.sv
// Converts raw SHT40 temperature/humidity words into centi-degC / centi-%RH
// using one shared 16-cycle shift-add multiplier, one channel per slot.
module sht40_convert #(
   parameter int T_SCALE   = 17500,
   parameter int T_OFFSET  = 4500,
   parameter int RH_SCALE  = 12500,
   parameter int RH_OFFSET = 600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Temperature_Raw,
   input  logic [15:0] Humidity_Raw,
   input  logic        Temp_Ready,
   input  logic        RH_Ready,
   input  logic        CRC_Error,
   output logic [15:0] Temp_Centi,
   output logic [15:0] RH_Centi,
   output logic        Temp_Valid,
   output logic        RH_Valid,
   output logic        Busy,
   output logic [7:0]  Drop_Count
);

   typedef enum logic [1:0] {IDLE, LOAD, MUL, FIN} state_t;

   localparam logic [14:0]        T_SCALE_W  = 15'(T_SCALE);
   localparam logic [14:0]        RH_SCALE_W = 15'(RH_SCALE);
   localparam logic signed [17:0] T_OFF_W    = 18'(T_OFFSET);
   localparam logic signed [17:0] RH_OFF_W   = 18'(RH_OFFSET);
   localparam logic signed [17:0] RH_MAX_W   = 18'sd10000;

   state_t      state_q, state_d;
   logic        t_rdy_q, rh_rdy_q;
   logic        t_pend_q, rh_pend_q;
   logic [15:0] t_word_q, rh_word_q;
   logic        sel_rh_q, sel_rh_d;
   logic [15:0] mplier_q;
   logic [31:0] mcand_q;
   logic [31:0] acc_q;
   logic [3:0]  cnt_q;
   logic [15:0] temp_q, rh_q;
   logic [7:0]  drop_q;

   logic        t_edge, rh_edge, t_acc, rh_acc;
   logic [1:0]  n_drop;
   logic [8:0]  drop_sum;
   logic        want;
   logic signed [17:0] t_res_w, rh_res_w;
   logic [15:0] t_res, rh_res;
   logic        fin_t, fin_rh;

   // A sample is a rising Ready edge; CRC_Error in that same cycle discards it.
   assign t_edge   = Temp_Ready & ~t_rdy_q;
   assign rh_edge  = RH_Ready & ~rh_rdy_q;
   assign t_acc    = t_edge & ~CRC_Error;
   assign rh_acc   = rh_edge & ~CRC_Error;
   assign n_drop   = {1'b0, t_edge & CRC_Error} + {1'b0, rh_edge & CRC_Error};
   assign drop_sum = {1'b0, drop_q} + {7'd0, n_drop};
   assign want     = t_pend_q | t_acc | rh_pend_q | rh_acc;

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_d  = state_q;
      sel_rh_d = sel_rh_q;
      unique case (state_q)
         IDLE, FIN: begin
            if (want) begin
               state_d  = LOAD;
               sel_rh_d = ~(t_pend_q | t_acc);
            end else begin
               state_d  = IDLE;
            end
         end
         LOAD:    state_d = MUL;
         MUL:     if (cnt_q == 4'd15) state_d = FIN;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: edge history, pending slots, multiplier, results, drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         t_rdy_q   <= Temp_Ready;
         rh_rdy_q  <= RH_Ready;
         t_pend_q  <= 1'b0;
         rh_pend_q <= 1'b0;
         t_word_q  <= '0;
         rh_word_q <= '0;
         sel_rh_q  <= 1'b0;
         mplier_q  <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         temp_q    <= '0;
         rh_q      <= '0;
         drop_q    <= '0;
      end else begin
         t_rdy_q  <= Temp_Ready;
         rh_rdy_q <= RH_Ready;
         sel_rh_q <= sel_rh_d;
         drop_q   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

         // A fresh edge wins over the LOAD-cycle clear: the new word stays pending.
         if (t_acc) begin
            t_word_q <= Temperature_Raw;
            t_pend_q <= 1'b1;
         end else if (state_q == LOAD && !sel_rh_q) begin
            t_pend_q <= 1'b0;
         end
         if (rh_acc) begin
            rh_word_q <= Humidity_Raw;
            rh_pend_q <= 1'b1;
         end else if (state_q == LOAD && sel_rh_q) begin
            rh_pend_q <= 1'b0;
         end

         case (state_q)
            LOAD: begin
               mplier_q <= sel_rh_q ? rh_word_q : t_word_q;
               mcand_q  <= {17'd0, sel_rh_q ? RH_SCALE_W : T_SCALE_W};
               acc_q    <= '0;
               cnt_q    <= '0;
            end
            MUL: begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mplier_q <= mplier_q >> 1;
               mcand_q  <= mcand_q << 1;
               cnt_q    <= cnt_q + 4'd1;
            end
            FIN: begin
               if (sel_rh_q) rh_q   <= rh_res;
               else          temp_q <= t_res;
            end
            default: ;
         endcase
      end
   end

   // Scale back by 2^16, remove offset; humidity is clamped to 0..100.00 %RH.
   assign t_res_w  = $signed({2'b00, acc_q[31:16]}) - T_OFF_W;
   assign rh_res_w = $signed({2'b00, acc_q[31:16]}) - RH_OFF_W;
   assign t_res    = t_res_w[15:0];

   always_comb begin
      rh_res = rh_res_w[15:0];
      if (rh_res_w < 0)             rh_res = 16'd0;
      else if (rh_res_w > RH_MAX_W) rh_res = 16'd10000;
   end

   // FSM outputs: the fresh result is presented during FIN alongside Valid.
   always_comb begin
      fin_t      = (state_q == FIN) && !sel_rh_q && !rst;
      fin_rh     = (state_q == FIN) &&  sel_rh_q && !rst;
      Busy       = (state_q != IDLE);
      Temp_Valid = fin_t;
      RH_Valid   = fin_rh;
      Temp_Centi = fin_t  ? t_res  : temp_q;
      RH_Centi   = fin_rh ? rh_res : rh_q;
      Drop_Count = drop_q;
   end

endmodule
